memory_game_ctrl: RTL and testbench

- Game-logic stage for the 5x4 card-matching game.
- Consumes the five debounced button levels and the 20-cell pair-ID layout from the random order generator.
- Owns the cursor, the flip/match state of every cell, and the mismatch reveal timer.
- Drives the pixel painter downstream, which reads cursor, face_up, matched and game_over each frame.

---
 rtl/memory_game_pkg.sv | 28 ++
 rtl/memory_game_ctrl_rise_edge.sv | 22 ++
 rtl/memory_game_ctrl.sv | 156 +++++++++++++++
 tb/tb_memory_game_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_game_pkg.sv
// Shared geometry, state encoding and helpers for the card-matching game logic.
package memory_game_pkg;

    localparam int GRID_SIZE_X = 5;
    localparam int GRID_SIZE_Y = 4;
    localparam int NUM_CELLS   = GRID_SIZE_X * GRID_SIZE_Y;
    localparam int NUM_PAIRS   = NUM_CELLS / 2;
    localparam int PAIR_ID_W   = 4;

    typedef enum logic [2:0] {
        PICK1,
        PICK2,
        COMPARE,
        SHOW,
        DONE
    } game_state_t;

    typedef logic [4:0] cell_idx_t;

    // Pair ID of cell c from the flat layout bus (cell i at bits [4i+3:4i]).
    function automatic logic [PAIR_ID_W-1:0] pair_of(
        input logic [NUM_CELLS*PAIR_ID_W-1:0] ids,
        input cell_idx_t                      c
    );
        return ids[int'(c)*PAIR_ID_W +: PAIR_ID_W];
    endfunction

endpackage

// File: rtl/memory_game_ctrl_rise_edge.sv
// Rising-edge detector: registered previous level, pulse is combinational so a
// press acts in the same cycle it is first seen.
module rise_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clock_25M,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic prev;

    // Track last sampled level; reset value high masks buttons held through reset.
    always_ff @(posedge clock_25M) begin
        if (reset) prev <= RST_VAL;
        else       prev <= level;
    end

    assign pulse = level & ~prev;

endmodule

// File: rtl/memory_game_ctrl.sv
// Game logic for the 5x4 card-matching game: cursor, flip/match state,
// mismatch reveal timer and the pick/compare/show/done sequencing.
module memory_game_ctrl
    import memory_game_pkg::*;
#(
    parameter int MISMATCH_FRAMES = 60
) (
    input  logic                            clock_25M,
    input  logic                            reset,
    input  logic                            frame,
    input  logic                            right,
    input  logic                            left,
    input  logic                            up,
    input  logic                            down,
    input  logic                            select,
    input  logic [NUM_CELLS*PAIR_ID_W-1:0]  card_pair_id,
    output logic [2:0]                      cursor_x,
    output logic [1:0]                      cursor_y,
    output logic [4:0]                      cursor_idx,
    output logic [NUM_CELLS-1:0]            face_up,
    output logic [NUM_CELLS-1:0]            matched,
    output logic [3:0]                      pairs_found,
    output logic [7:0]                      attempts,
    output logic                            game_over
);

    localparam int HOLD_W = $clog2(MISMATCH_FRAMES + 1);

    // Button order: {select, down, up, left, right}
    logic [4:0] btn_lvl, btn_rise;
    assign btn_lvl = {select, down, up, left, right};

    for (genvar b = 0; b < 5; b++) begin : g_btn
        rise_edge #(.RST_VAL(1'b1)) u_edge (
            .clock_25M (clock_25M),
            .reset     (reset),
            .level     (btn_lvl[b]),
            .pulse     (btn_rise[b])
        );
    end

    logic r_p, l_p, u_p, d_p, s_p;
    assign {s_p, d_p, u_p, l_p, r_p} = btn_rise;

    game_state_t           state, state_nxt;
    cell_idx_t             first, first_nxt, second, second_nxt;
    logic [HOLD_W-1:0]     hold, hold_nxt;
    logic [2:0]            x_nxt;
    logic [1:0]            y_nxt;
    logic [4:0]            idx_nxt;
    logic [NUM_CELLS-1:0]  face_nxt, match_nxt;
    logic [3:0]            pairs_nxt;
    logic [7:0]            att_nxt;
    logic                  pick_ok;

    // State and output registers.
    always_ff @(posedge clock_25M) begin
        if (reset) begin
            state       <= PICK1;
            first       <= '0;
            second      <= '0;
            hold        <= '0;
            cursor_x    <= '0;
            cursor_y    <= '0;
            cursor_idx  <= '0;
            face_up     <= '0;
            matched     <= '0;
            pairs_found <= '0;
            attempts    <= '0;
        end else begin
            state       <= state_nxt;
            first       <= first_nxt;
            second      <= second_nxt;
            hold        <= hold_nxt;
            cursor_x    <= x_nxt;
            cursor_y    <= y_nxt;
            cursor_idx  <= idx_nxt;
            face_up     <= face_nxt;
            matched     <= match_nxt;
            pairs_found <= pairs_nxt;
            attempts    <= att_nxt;
        end
    end

    // Cursor movement: one clamped step per edge, opposing edges cancel, frozen in DONE.
    always_comb begin
        x_nxt = cursor_x;
        y_nxt = cursor_y;
        if (state != DONE) begin
            if (r_p && !l_p && cursor_x != 3'(GRID_SIZE_X - 1)) x_nxt = cursor_x + 3'd1;
            if (l_p && !r_p && cursor_x != 3'd0)                x_nxt = cursor_x - 3'd1;
            if (u_p && !d_p && cursor_y != 2'd0)                y_nxt = cursor_y - 2'd1;
            if (d_p && !u_p && cursor_y != 2'(GRID_SIZE_Y - 1)) y_nxt = cursor_y + 2'd1;
        end
        idx_nxt = cell_idx_t'(y_nxt) * cell_idx_t'(GRID_SIZE_X) + cell_idx_t'(x_nxt);
    end

    // Game sequencing; select always uses the pre-move cursor.
    always_comb begin
        state_nxt  = state;
        first_nxt  = first;
        second_nxt = second;
        hold_nxt   = hold;
        face_nxt   = face_up;
        match_nxt  = matched;
        pairs_nxt  = pairs_found;
        att_nxt    = attempts;
        pick_ok    = !face_up[cursor_idx] && !matched[cursor_idx];
        case (state)
            PICK1: if (s_p && pick_ok) begin
                face_nxt[cursor_idx] = 1'b1;
                first_nxt            = cursor_idx;
                state_nxt            = PICK2;
            end
            PICK2: if (s_p && pick_ok) begin
                face_nxt[cursor_idx] = 1'b1;
                second_nxt           = cursor_idx;
                if (attempts != 8'hFF) att_nxt = attempts + 8'd1;
                state_nxt            = COMPARE;
            end
            COMPARE: begin
                if (pair_of(card_pair_id, first) == pair_of(card_pair_id, second)) begin
                    match_nxt[first]  = 1'b1;
                    match_nxt[second] = 1'b1;
                    face_nxt[first]   = 1'b0;
                    face_nxt[second]  = 1'b0;
                    pairs_nxt         = pairs_found + 4'd1;
                    state_nxt = (pairs_found == 4'(NUM_PAIRS - 1)) ? DONE : PICK1;
                end else begin
                    hold_nxt  = '0;
                    state_nxt = SHOW;
                end
            end
            SHOW: if (frame) begin
                if (hold == HOLD_W'(MISMATCH_FRAMES - 1)) begin
                    face_nxt[first]  = 1'b0;
                    face_nxt[second] = 1'b0;
                    state_nxt        = PICK1;
                end else begin
                    hold_nxt = hold + 1'b1;
                end
            end
            DONE: if (s_p) begin
                face_nxt  = '0;
                match_nxt = '0;
                pairs_nxt = '0;
                att_nxt   = '0;
                state_nxt = PICK1;
            end
            default: state_nxt = PICK1;
        endcase
    end

    assign game_over = (state == DONE);

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Bench for memory_game_ctrl: directed scenarios plus random button traffic,
// every cycle compared against a behavioural model of the game rules.
module tb_memory_game_ctrl;

    localparam int MF = 3;
    localparam logic [4:0] B_R = 5'h01, B_L = 5'h02, B_U = 5'h04, B_D = 5'h08, B_S = 5'h10;

    logic        clock_25M = 1'b0;
    logic        reset = 1'b1, frame = 1'b0;
    logic        right = 1'b0, left = 1'b0, up = 1'b0, down = 1'b0, select = 1'b0;
    logic [79:0] card_pair_id = '0;
    logic [2:0]  cursor_x;
    logic [1:0]  cursor_y;
    logic [4:0]  cursor_idx;
    logic [19:0] face_up, matched;
    logic [3:0]  pairs_found;
    logic [7:0]  attempts;
    logic        game_over;

    memory_game_ctrl #(.MISMATCH_FRAMES(MF)) dut (
        .clock_25M(clock_25M), .reset(reset), .frame(frame),
        .right(right), .left(left), .up(up), .down(down), .select(select),
        .card_pair_id(card_pair_id),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_idx(cursor_idx),
        .face_up(face_up), .matched(matched), .pairs_found(pairs_found),
        .attempts(attempts), .game_over(game_over)
    );

    always #20 clock_25M = ~clock_25M;

    int n_chk = 0, n_err = 0;
    bit chk_en = 0;

    // Behavioural model: cursor coordinates, revealed/removed sets, picks of the
    // current attempt, and a countdown of frames left to show a failed pair.
    int          lay[20];
    int          m_x, m_y, m_pairs, m_att, show_left;
    logic [19:0] m_face, m_match;
    bit          m_over, cmp_due;
    int          picks[$];
    logic [4:0]  m_prev = 5'h1F;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [4:0] e;
        int  sel;
        bit  was_over;
        if (reset) begin
            m_x = 0; m_y = 0; m_face = '0; m_match = '0; m_pairs = 0; m_att = 0;
            m_over = 0; cmp_due = 0; show_left = 0; picks.delete(); m_prev = 5'h1F;
            return;
        end
        e = {select, down, up, left, right} & ~m_prev;
        m_prev = {select, down, up, left, right};
        sel = m_y * 5 + m_x;
        was_over = m_over;
        if (m_over) begin
            if (e[4]) begin m_face = '0; m_match = '0; m_pairs = 0; m_att = 0; m_over = 0; end
        end else if (cmp_due) begin
            cmp_due = 0;
            if (lay[picks[0]] == lay[picks[1]]) begin
                m_match[picks[0]] = 1'b1; m_match[picks[1]] = 1'b1;
                m_face[picks[0]] = 1'b0;  m_face[picks[1]] = 1'b0;
                picks.delete();
                m_pairs++;
                if (m_pairs == 10) m_over = 1;
            end else show_left = MF;
        end else if (show_left > 0) begin
            if (frame) begin
                show_left--;
                if (show_left == 0) begin
                    m_face[picks[0]] = 1'b0; m_face[picks[1]] = 1'b0;
                    picks.delete();
                end
            end
        end else if (e[4] && !m_face[sel] && !m_match[sel]) begin
            m_face[sel] = 1'b1;
            picks.push_back(sel);
            if (picks.size() == 2) begin
                if (m_att < 255) m_att++;
                cmp_due = 1;
            end
        end
        if (!was_over) begin
            if (e[0] && !e[1] && m_x < 4) m_x++;
            if (e[1] && !e[0] && m_x > 0) m_x--;
            if (e[2] && !e[3] && m_y > 0) m_y--;
            if (e[3] && !e[2] && m_y < 3) m_y++;
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(posedge clock_25M) begin
        #2;
        if (chk_en) begin
            chk("cursor_x", 32'(cursor_x), 32'(m_x));
            chk("cursor_y", 32'(cursor_y), 32'(m_y));
            chk("cursor_idx", 32'(cursor_idx), 32'(m_y * 5 + m_x));
            chk("face_up", 32'(face_up), 32'(m_face));
            chk("matched", 32'(matched), 32'(m_match));
            chk("pairs_found", 32'(pairs_found), 32'(m_pairs));
            chk("attempts", 32'(attempts), 32'(m_att));
            chk("game_over", 32'(game_over), 32'(m_over));
        end
    end

    task automatic tick(input logic [4:0] btn, input logic frm, input logic rst);
        {select, down, up, left, right} = btn;
        frame = frm;
        reset = rst;
        model_step();
        @(posedge clock_25M);
        @(negedge clock_25M);
    endtask

    task automatic press(input logic [4:0] btn);
        tick(btn, 1'b0, 1'b0);
        tick(5'h00, 1'b0, 1'b0);
    endtask

    task automatic goto_cell(input int c);
        for (int i = 0; i < 8 && m_x < c % 5; i++) press(B_R);
        for (int i = 0; i < 8 && m_x > c % 5; i++) press(B_L);
        for (int i = 0; i < 8 && m_y < c / 5; i++) press(B_D);
        for (int i = 0; i < 8 && m_y > c / 5; i++) press(B_U);
    endtask

    task automatic pick(input int c);
        goto_cell(c);
        press(B_S);
    endtask

    task automatic load_layout();
        for (int i = 0; i < 20; i++) card_pair_id[4*i +: 4] = 4'(lay[i]);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Layout: cell i holds pair ((i/2)+3)%10, so cells 0,1 are pair 3.
        for (int i = 0; i < 20; i++) lay[i] = ((i / 2) + 3) % 10;
        load_layout();
        @(negedge clock_25M);
        tick(5'h00, 1'b0, 1'b1);
        chk_en = 1;
        tick(5'h00, 1'b0, 1'b0);
        chk("pin_reset_idx", 32'(cursor_idx), 0);
        chk("pin_reset_face", 32'(face_up), 0);
        chk("pin_reset_over", 32'(game_over), 0);

        // Cursor clamping
        press(B_L); press(B_U);
        chk("pin_clamp_x0", 32'(cursor_x), 0);
        chk("pin_clamp_y0", 32'(cursor_y), 0);
        for (int i = 0; i < 6; i++) press(B_R);
        for (int i = 0; i < 5; i++) press(B_D);
        chk("pin_clamp_x4", 32'(cursor_x), 4);
        chk("pin_clamp_y3", 32'(cursor_y), 3);
        chk("pin_clamp_idx19", 32'(cursor_idx), 19);
        press(B_R | B_L);
        chk("pin_rl_cancel", 32'(cursor_x), 4);
        goto_cell(0);

        // Match on cells 0 and 1
        press(B_S);
        press(B_R);
        tick(B_S, 1'b0, 1'b0);
        chk("pin_match_faceup", 32'(face_up[1:0]), 32'h3);
        tick(5'h00, 1'b0, 1'b0);
        chk("pin_match_matched", 32'(matched[1:0]), 32'h3);
        chk("pin_match_face0", 32'(face_up), 0);
        chk("pin_match_pairs", 32'(pairs_found), 1);
        chk("pin_match_att", 32'(attempts), 1);

        // Invalid picks: matched cell, then reselecting the first card
        pick(0);
        chk("pin_inv_matched", 32'(face_up), 0);
        pick(2); pick(2);
        chk("pin_inv_reselect", 32'(face_up), 32'h4);
        chk("pin_inv_att", 32'(attempts), 1);
        pick(3);
        chk("pin_inv_pair2", 32'(matched), 32'hF);

        // Mismatch: cell 18 (pair 2) vs cell 4 (pair 5)
        pick(18); pick(4);
        tick(5'h00, 1'b1, 1'b0); tick(5'h00, 1'b0, 1'b0);
        tick(5'h00, 1'b1, 1'b0); tick(5'h00, 1'b0, 1'b0);
        chk("pin_show_face", 32'(face_up), 32'h40010);
        press(B_D); press(B_S);
        chk("pin_show_sel_ign", 32'(face_up), 32'h40010);
        tick(5'h00, 1'b1, 1'b0);
        chk("pin_show_clear", 32'(face_up), 0);
        chk("pin_show_att", 32'(attempts), 3);

        // Reset mid-SHOW with select held through it
        pick(6); pick(8);
        tick(5'h00, 1'b1, 1'b0);
        tick(B_S, 1'b0, 1'b1);
        tick(B_S, 1'b0, 1'b0);
        tick(B_S, 1'b0, 1'b0);
        chk("pin_rst_face", 32'(face_up), 0);
        chk("pin_rst_matched", 32'(matched), 0);
        chk("pin_rst_att", 32'(attempts), 0);
        chk("pin_rst_idx", 32'(cursor_idx), 0);
        tick(5'h00, 1'b0, 1'b0);

        // Full game without misses
        for (int k = 0; k < 10; k++) begin pick(2 * k); pick(2 * k + 1); end
        chk("pin_full_pairs", 32'(pairs_found), 10);
        chk("pin_full_att", 32'(attempts), 10);
        chk("pin_full_over", 32'(game_over), 1);
        press(B_L);
        chk("pin_full_nomove", 32'(cursor_idx), 19);
        press(B_S);
        chk("pin_restart_matched", 32'(matched), 0);
        chk("pin_restart_att", 32'(attempts), 0);
        chk("pin_restart_over", 32'(game_over), 0);
        chk("pin_restart_idx", 32'(cursor_idx), 19);

        // Random traffic on a shuffled layout
        for (int i = 0; i < 20; i++) lay[i] = i / 2;
        for (int i = 19; i > 0; i--) begin
            int j, t;
            j = $urandom_range(i, 0);
            t = lay[i]; lay[i] = lay[j]; lay[j] = t;
        end
        load_layout();
        tick(5'h00, 1'b0, 1'b1);
        for (int n = 0; n < 4000; n++) begin
            logic [4:0] b;
            for (int k = 0; k < 5; k++) b[k] = ($urandom_range(3, 0) == 0);
            tick(b, 1'($urandom_range(3, 0) == 0), 1'($urandom_range(499, 0) == 0));
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
